// File: rtl/serdes_pkg.sv
// Shared definitions for the serial/parallel conversion blocks.
package serdes_pkg;

    typedef enum logic {
        BIT_LSB_FIRST = 1'b0,
        BIT_MSB_FIRST = 1'b1
    } bit_order_t;

    // Width needed to hold a bit count from 0 up to and including w.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/shift_deserializer_out_stage.sv
// One-word valid/ready holding register for the deserializer output.
module deser_out_stage #(
    parameter int DATA_WIDTH = 8,
    parameter int BITS_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic [BITS_WIDTH-1:0] load_bits,
    input  logic                  word_ready,
    output logic                  load_ok,
    output logic                  word_valid,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [BITS_WIDTH-1:0] word_bits
);

    // The stage can take a new word when empty or when its word leaves on this edge.
    assign load_ok = !word_valid || word_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            word_valid <= 1'b0;
            dout       <= '0;
            word_bits  <= '0;
        end else if (load) begin
            word_valid <= 1'b1;
            dout       <= load_data;
            word_bits  <= load_bits;
        end else if (word_valid && word_ready) begin
            word_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/shift_deserializer.sv
// Serial-to-parallel converter: bit handshake in, word handshake out, two words of buffering.
module shift_deserializer
    import serdes_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 bit_valid,
    input  logic                                 bit_in,
    output logic                                 bit_ready,
    input  logic                                 msb_first,
    input  logic                                 flush,
    output logic                                 word_valid,
    input  logic                                 word_ready,
    output logic [DATA_WIDTH-1:0]                dout,
    output logic [cnt_width(DATA_WIDTH)-1:0]     word_bits
);

    localparam int CW = cnt_width(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] acc;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         pend_bits;
    logic                  acc_full;
    logic                  rst_hold;
    bit_order_t            order;

    bit_order_t            cur_order;
    logic                  accept;
    logic                  complete;
    logic                  do_flush;
    logic                  emit;
    logic                  load;
    logic                  load_ok;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] word_data;
    logic [CW-1:0]         emit_bits;
    logic [CW-1:0]         word_len;

    // rst_hold keeps bit_ready low through the cycle that follows reset.
    assign bit_ready = !acc_full && !rst_hold;

    always_comb begin
        accept    = bit_valid && bit_ready;
        cur_order = (cnt == '0) ? bit_order_t'(msb_first) : order;
        shifted   = acc;
        if (accept) begin
            if (cur_order == BIT_MSB_FIRST) begin
                shifted = {acc[DATA_WIDTH-2:0], bit_in};
            end else begin
                shifted = {bit_in, acc[DATA_WIDTH-1:1]};
            end
        end
        complete  = accept && (cnt == CW'(DATA_WIDTH - 1));
        do_flush  = flush && !acc_full && ((cnt != '0) || accept);
        emit      = complete || do_flush;
        emit_bits = complete ? CW'(DATA_WIDTH) : (accept ? cnt + CW'(1) : cnt);
        load      = (acc_full || emit) && load_ok;
        word_data = acc_full ? acc : shifted;
        word_len  = acc_full ? pend_bits : emit_bits;
    end

    // A word that finds the output stage busy parks in acc until the stage frees up.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            pend_bits <= '0;
            acc_full  <= 1'b0;
            order     <= BIT_LSB_FIRST;
            rst_hold  <= 1'b1;
        end else begin
            rst_hold <= 1'b0;
            if (acc_full) begin
                if (load_ok) begin
                    acc      <= '0;
                    cnt      <= '0;
                    acc_full <= 1'b0;
                end
            end else if (emit) begin
                cnt <= '0;
                if (load_ok) begin
                    acc <= '0;
                end else begin
                    acc       <= shifted;
                    pend_bits <= emit_bits;
                    acc_full  <= 1'b1;
                end
            end else if (accept) begin
                acc <= shifted;
                cnt <= cnt + CW'(1);
            end
            if (accept && (cnt == '0)) begin
                order <= cur_order;
            end
        end
    end

    deser_out_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .BITS_WIDTH (CW)
    ) u_out_stage (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_data  (word_data),
        .load_bits  (word_len),
        .word_ready (word_ready),
        .load_ok    (load_ok),
        .word_valid (word_valid),
        .dout       (dout),
        .word_bits  (word_bits)
    );

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed and randomized checks of shift_deserializer against a queue-based word model.
module tb_shift_deserializer;

    localparam int W  = 8;
    localparam int BW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          bit_valid;
    logic          bit_in;
    logic          bit_ready;
    logic          msb_first;
    logic          flush;
    logic          word_valid;
    logic          word_ready;
    logic [W-1:0]  dout;
    logic [BW-1:0] word_bits;

    typedef struct {
        logic [W-1:0] data;
        int           bits;
    } word_t;

    int           checks = 0;
    int           fails  = 0;
    word_t        expq[$];
    bit           partBits[$];
    logic         partOrder;
    bit           rstSeen = 1'b1;
    bit           lastAccept;
    logic [W-1:0] lastData;
    int           lastBits;

    shift_deserializer #(.DATA_WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .bit_ready  (bit_ready),
        .msb_first  (msb_first),
        .flush      (flush),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .dout       (dout),
        .word_bits  (word_bits)
    );

    always #5 clk = ~clk;

    // Place k collected bits into a word: MSB-first fills the low k bits, LSB-first the high k bits.
    function automatic logic [W-1:0] packWord(input bit b[$], input logic msb);
        logic [W-1:0] v;
        int k;
        v = '0;
        k = b.size();
        for (int i = 0; i < k; i++) begin
            if (msb) v[k-1-i] = b[i];
            else     v[W-k+i] = b[i];
        end
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic b, input logic m,
                                 input logic f, input logic wr);
        bit_valid  = v;
        bit_in     = b;
        msb_first  = m;
        flush      = f;
        word_ready = wr;
    endtask

    task automatic emitPartial();
        word_t w;
        w.data = packWord(partBits, partOrder);
        w.bits = partBits.size();
        expq.push_back(w);
        partBits.delete();
    endtask

    // Check outputs against the model, advance the model for this edge, then clock.
    task automatic cycle();
        int    held0;
        word_t w;
        held0 = expq.size();
        lastAccept = 1'b0;
        checkOutput("word_valid", word_valid, held0 > 0);
        if (!rst) begin
            checkOutput("bit_ready", bit_ready, !rstSeen && held0 < 2);
            if (held0 > 0 && word_ready) begin
                w = expq.pop_front();
                checkOutput("dout", dout, w.data);
                checkOutput("word_bits", word_bits, w.bits);
                lastData = dout;
                lastBits = word_bits;
            end
            lastAccept = bit_valid && !rstSeen && held0 < 2;
            if (lastAccept) begin
                if (partBits.size() == 0) partOrder = msb_first;
                partBits.push_back(bit_in);
                if (partBits.size() == W) emitPartial();
            end
            if (flush && held0 < 2 && partBits.size() > 0) emitPartial();
        end
        @(posedge clk);
        #1;
        if (rst) begin
            expq.delete();
            partBits.delete();
            rstSeen = 1'b1;
        end else begin
            rstSeen = 1'b0;
        end
    endtask

    task automatic sendBit(input logic b, input logic m, input logic wr);
        int guard;
        guard = 0;
        applyStimulus(1'b1, b, m, 1'b0, wr);
        do begin
            cycle();
            guard++;
        end while (!lastAccept && guard < 50);
        checkOutput("bit accepted", lastAccept, 1'b1);
        bit_valid = 1'b0;
    endtask

    task automatic sendWord(input logic [W-1:0] pattern, input int n,
                            input logic m, input logic wr);
        for (int i = 0; i < n; i++) sendBit(pattern[n-1-i], m, wr);
    endtask

    task automatic idle(input int n, input logic wr);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, wr);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("reset word_valid", word_valid, 1'b0);
        checkOutput("reset dout", dout, '0);
        checkOutput("reset word_bits", word_bits, '0);
        checkOutput("reset bit_ready", bit_ready, 1'b0);
        rst = 1'b0;
        idle(1, 1'b1);
        checkOutput("ready after reset", bit_ready, 1'b1);

        $display("[TB] test 1: MSB-first full word");
        sendWord(8'b10110010, 8, 1'b1, 1'b1);
        checkOutput("t1 word_valid", word_valid, 1'b1);
        idle(1, 1'b1);
        checkOutput("t1 dout", lastData, 8'hB2);
        checkOutput("t1 word_bits", lastBits, 8);
        checkOutput("t1 valid one cycle", word_valid, 1'b0);

        $display("[TB] test 2: LSB-first full word");
        sendWord(8'b10110010, 8, 1'b0, 1'b1);
        idle(1, 1'b1);
        checkOutput("t2 dout", lastData, 8'h4D);
        checkOutput("t2 word_bits", lastBits, 8);

        $display("[TB] test 3: back-pressure with two buffered words");
        sendWord(8'hA5, 8, 1'b1, 1'b0);
        sendWord(8'h3C, 8, 1'b1, 1'b0);
        idle(1, 1'b0);
        checkOutput("t3 dout held", dout, 8'hA5);
        checkOutput("t3 bit_ready stalled", bit_ready, 1'b0);
        idle(1, 1'b1);
        checkOutput("t3 first word", lastData, 8'hA5);
        idle(1, 1'b1);
        checkOutput("t3 second word", lastData, 8'h3C);
        checkOutput("t3 bit_ready resumed", bit_ready, 1'b1);

        $display("[TB] test 4: flush of partial words");
        sendWord(8'b110, 3, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        cycle();
        idle(1, 1'b1);
        checkOutput("t4 msb dout", lastData, 8'h06);
        checkOutput("t4 msb word_bits", lastBits, 3);
        sendWord(8'b110, 3, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        cycle();
        idle(1, 1'b1);
        checkOutput("t4 lsb dout", lastData, 8'h60);
        checkOutput("t4 lsb word_bits", lastBits, 3);
        sendWord(8'b10, 2, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        cycle();
        idle(1, 1'b1);
        checkOutput("t4 flush+bit dout", lastData, 8'h05);
        checkOutput("t4 flush+bit word_bits", lastBits, 3);

        $display("[TB] test 5: reset mid-word");
        sendWord(8'b10101, 5, 1'b1, 1'b1);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle();
        checkOutput("t5 word_valid in rst", word_valid, 1'b0);
        checkOutput("t5 bit_ready in rst", bit_ready, 1'b0);
        rst = 1'b0;
        idle(1, 1'b1);
        sendWord(8'hFF, 8, 1'b1, 1'b1);
        idle(1, 1'b1);
        checkOutput("t5 dout", lastData, 8'hFF);
        checkOutput("t5 word_bits", lastBits, 8);

        $display("[TB] test 6: empty flush and mid-word order change");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        cycle();
        checkOutput("t6 empty flush", word_valid, 1'b0);
        sendBit(1'b1, 1'b1, 1'b1);
        sendBit(1'b0, 1'b1, 1'b1);
        sendBit(1'b1, 1'b1, 1'b1);
        sendBit(1'b1, 1'b0, 1'b1);
        sendBit(1'b0, 1'b0, 1'b1);
        sendBit(1'b0, 1'b1, 1'b1);
        sendBit(1'b1, 1'b0, 1'b1);
        sendBit(1'b0, 1'b0, 1'b1);
        idle(1, 1'b1);
        checkOutput("t6 dout", lastData, 8'hB2);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            applyStimulus($urandom_range(0, 3) != 0, 1'($urandom),
                          1'($urandom), $urandom_range(0, 9) == 0,
                          $urandom_range(0, 2) != 0);
            cycle();
        end
        rst = 1'b0;
        flush = 1'b0;
        idle(6, 1'b1);
        checkOutput("drain queue empty", expq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
